// File: rtl/boot_copy_pkg.sv
// Shared types and constants for the boot-time flash-to-RAM copy controller.
// The CHK state only exists when BOOT_COPY_CHKSUM_EN is defined.
package boot_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FLASH_AW   = 24;
  localparam int unsigned RAM_AW     = 32;

`ifdef BOOT_COPY_CHKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;
`endif

  // RAM write payload held stable while waiting for ram_ready
  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

  // Word index must be able to reach WORDS (trailer index / post-increment)
  function automatic int unsigned idx_width(input int unsigned words);
    return (words == 0) ? 1 : $clog2(words + 1);
  endfunction

endpackage

// File: rtl/boot_copy_timer.sv
// Flash-read watchdog: counts enabled cycles, expire_c flags the TIMEOUT-th one.
module boot_copy_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CW-1:0] count;

  // Count holds at LIMIT so it never wraps back to a non-expired value
  assign expire_c = (count == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expire_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/boot_copy_ctrl.sv
// Copies WORDS flash words into RAM before releasing the CPU from reset.
// Define BOOT_COPY_CHKSUM_EN to verify a trailing flash checksum word.
module boot_copy_ctrl
  import boot_copy_pkg::*;
#(
  parameter int unsigned           WORDS      = 1024,
  parameter logic [FLASH_AW-1:0]   FLASH_BASE = 24'h000000,
  parameter logic [RAM_AW-1:0]     RAM_BASE   = 32'h2000_0000,
  parameter int unsigned           TIMEOUT    = 256
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                flash2ram_en,
  output logic                flash_req,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic                flash_ack,
  input  logic [DATA_W-1:0]   flash_rdata,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_ready,
  output logic                cpu_rst_b,
  output logic                copy_done,
  output logic                copy_err
);

  localparam int unsigned      IDX_W         = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'((WORDS == 0) ? 0 : WORDS - 1);
  localparam bit               COPY_NONEMPTY = (WORDS != 0);

  state_e            state;
  state_e            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_nxt;
  logic              tmr_en_c;
  logic              tmr_expire_c;
  logic              rd_nxt_c;
  logic              wr_nxt_c;
  ram_wr_t           ram_wr_q;
`ifdef BOOT_COPY_CHKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_nxt;
`endif

  // Timer runs only while a flash read is outstanding; cleared otherwise
  boot_copy_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (~tmr_en_c),
    .en       (tmr_en_c),
    .expire_c (tmr_expire_c)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = data_q;
    tmr_en_c  = 1'b0;
`ifdef BOOT_COPY_CHKSUM_EN
    sum_nxt   = sum_q;
`endif
    case (state)
      IDLE: begin
        state_nxt = (flash2ram_en && COPY_NONEMPTY) ? RD : DONE;
      end
      RD: begin
        tmr_en_c = 1'b1;
        if (flash_ack) begin
          data_nxt  = flash_rdata;
          state_nxt = WR;
        end else if (tmr_expire_c) begin
          state_nxt = ERR;
        end
      end
      WR: begin
        if (ram_ready) begin
          idx_nxt = idx + IDX_W'(1);
`ifdef BOOT_COPY_CHKSUM_EN
          sum_nxt   = sum_q + data_q;
          state_nxt = (idx == LAST_IDX) ? CHK : RD;
`else
          state_nxt = (idx == LAST_IDX) ? DONE : RD;
`endif
        end
      end
`ifdef BOOT_COPY_CHKSUM_EN
      // Trailer word is read at idx == WORDS and compared, never written
      CHK: begin
        tmr_en_c = 1'b1;
        if (flash_ack) begin
          state_nxt = (flash_rdata == sum_q) ? DONE : ERR;
        end else if (tmr_expire_c) begin
          state_nxt = ERR;
        end
      end
`endif
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BOOT_COPY_CHKSUM_EN
  assign rd_nxt_c = (state_nxt == RD) || (state_nxt == CHK);
`else
  assign rd_nxt_c = (state_nxt == RD);
`endif
  assign wr_nxt_c = (state_nxt == WR);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      data_q <= data_nxt;
    end
  end

`ifdef BOOT_COPY_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_nxt;
    end
  end
`endif

  // Outputs decoded from next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      flash_req  <= 1'b0;
      flash_addr <= '0;
      ram_we     <= 1'b0;
      ram_wr_q   <= '0;
      cpu_rst_b  <= 1'b0;
      copy_done  <= 1'b0;
      copy_err   <= 1'b0;
    end else begin
      flash_req     <= rd_nxt_c;
      flash_addr    <= rd_nxt_c ? FLASH_BASE + FLASH_AW'(idx_nxt) * FLASH_AW'(WORD_BYTES) : '0;
      ram_we        <= wr_nxt_c;
      ram_wr_q.addr <= wr_nxt_c ? RAM_BASE + RAM_AW'(idx_nxt) * RAM_AW'(WORD_BYTES) : '0;
      ram_wr_q.data <= wr_nxt_c ? data_nxt : '0;
      copy_done     <= (state_nxt == DONE);
      copy_err      <= (state_nxt == ERR);
      // CPU leaves reset one cycle after DONE and stays out until rst_b
      cpu_rst_b     <= cpu_rst_b | (state == DONE);
    end
  end

  assign ram_addr  = ram_wr_q.addr;
  assign ram_wdata = ram_wr_q.data;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Self-checking bench for boot_copy_ctrl (WORDS=4, TIMEOUT=8); flash/RAM
// responders and expectations come from a word-array model of the copy.
module tb_boot_copy_ctrl;

  localparam int unsigned WORDS      = 4;
  localparam int unsigned TIMEOUT    = 8;
  localparam logic [23:0] FLASH_BASE = 24'h000000;
  localparam logic [31:0] RAM_BASE   = 32'h2000_0000;
`ifdef BOOT_COPY_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk          = 1'b0;
  logic        rst_b        = 1'b0;
  logic        flash2ram_en = 1'b0;
  logic        flash_ack    = 1'b0;
  logic [31:0] flash_rdata  = '0;
  logic        ram_ready    = 1'b0;
  logic        flash_req;
  logic [23:0] flash_addr;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_rst_b;
  logic        copy_done;
  logic        copy_err;

  boot_copy_ctrl #(
    .WORDS      (WORDS),
    .FLASH_BASE (FLASH_BASE),
    .RAM_BASE   (RAM_BASE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .flash2ram_en (flash2ram_en),
    .flash_req    (flash_req),
    .flash_addr   (flash_addr),
    .flash_ack    (flash_ack),
    .flash_rdata  (flash_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_ready    (ram_ready),
    .cpu_rst_b    (cpu_rst_b),
    .copy_done    (copy_done),
    .copy_err     (copy_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] flash_mem [WORDS+1];
  int          res_writes;
  int          res_rd_cycles;
  bit          res_end;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < WORDS; i++) s = s + flash_mem[i];
    return s;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_flash_req"},  32'(flash_req), 32'd0);
    chk({tag, "_flash_addr"}, 32'(flash_addr), 32'd0);
    chk({tag, "_ram_we"},     32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"},   ram_addr, 32'd0);
    chk({tag, "_ram_wdata"},  ram_wdata, 32'd0);
    chk({tag, "_cpu_rst_b"},  32'(cpu_rst_b), 32'd0);
    chk({tag, "_copy_done"},  32'(copy_done), 32'd0);
    chk({tag, "_copy_err"},   32'(copy_err), 32'd0);
  endtask

  task automatic do_reset(input bit en);
    rst_b        = 1'b0;
    flash_ack    = 1'b0;
    ram_ready    = 1'b0;
    flash2ram_en = en;
    tick();
    tick();
    chk_quiet("rst");
    rst_b = 1'b1;
  endtask

  // Acts as flash and RAM slave; ack_dly==0 means flash never answers.
  // Stops at DONE/ERR, at the budget, or when word abort_word is requested.
  task automatic run_copy(input int ack_dly, input int rdy_dly, input bit rnd,
                          input int abort_word, input int budget);
    int          fcnt, rcnt, widx, cur_ack, cur_rdy;
    bit          ack_drop, rdy_drop;
    logic [23:0] efa;
    fcnt = 0; rcnt = 0; widx = 0; ack_drop = 0; rdy_drop = 0;
    cur_ack = rnd ? int'($urandom_range(1, 4)) : ack_dly;
    cur_rdy = rnd ? int'($urandom_range(1, 4)) : rdy_dly;
    res_rd_cycles = 0;
    res_end       = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      tick();
      flash_ack   = 1'b0;
      ram_ready   = 1'b0;
      flash_rdata = $urandom();
      if (ack_drop) chk("flash_req_drop", 32'(flash_req), 32'd0);
      if (rdy_drop) chk("ram_we_drop", 32'(ram_we), 32'd0);
      ack_drop = 0;
      rdy_drop = 0;
      chk("req_we_excl", 32'(flash_req & ram_we), 32'd0);
      if (copy_done || copy_err) begin
        res_end = 1;
        chk("cpu_rst_b_lag", 32'(cpu_rst_b), 32'd0);
        break;
      end
      if (flash_req) begin
        if (abort_word >= 0 && widx == abort_word) break;
        efa = FLASH_BASE + 24'(widx * 4);
        chk("flash_addr", 32'(flash_addr), 32'(efa));
        res_rd_cycles++;
        fcnt++;
        if (cur_ack != 0 && fcnt == cur_ack) begin
          flash_ack   = 1'b1;
          flash_rdata = flash_mem[widx];
          fcnt        = 0;
          ack_drop    = 1;
          cur_ack     = rnd ? int'($urandom_range(1, 4)) : ack_dly;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          ram_ready = 1'b1;
        end
      end
      if (ram_we) begin
        chk("ram_addr", ram_addr, RAM_BASE + 32'(widx * 4));
        chk("ram_wdata", ram_wdata, flash_mem[widx]);
        rcnt++;
        if (rcnt == cur_rdy) begin
          ram_ready = 1'b1;
          rcnt      = 0;
          widx++;
          rdy_drop  = 1;
          cur_rdy   = rnd ? int'($urandom_range(1, 4)) : rdy_dly;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          flash_ack = 1'b1;
        end
      end
    end
    flash_ack  = 1'b0;
    ram_ready  = 1'b0;
    res_writes = widx;
  endtask

  task automatic finish_check(input string tag, input bit exp_ok);
    chk({tag, "_end_reached"}, 32'(res_end), 32'd1);
    chk({tag, "_copy_done"},   32'(copy_done), 32'(exp_ok));
    chk({tag, "_copy_err"},    32'(copy_err), 32'(!exp_ok));
    chk({tag, "_writes"},      32'(res_writes), 32'(WORDS));
    tick();
    chk({tag, "_cpu_rst_b"},   32'(cpu_rst_b), 32'(exp_ok));
    chk({tag, "_req_idle"},    32'(flash_req | ram_we), 32'd0);
    tick();
    chk({tag, "_done_sticky"}, 32'(copy_done), 32'(exp_ok));
    chk({tag, "_err_sticky"},  32'(copy_err), 32'(!exp_ok));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_ok;

    // Skip path: no copy request at reset release
    do_reset(1'b0);
    tick();
    chk("skip_done", 32'(copy_done), 32'd1);
    chk("skip_req", 32'(flash_req), 32'd0);
    chk("skip_cpu_lag", 32'(cpu_rst_b), 32'd0);
    flash2ram_en = 1'b1;
    tick();
    chk("skip_cpu_rst_b", 32'(cpu_rst_b), 32'd1);
    repeat (3) tick();
    chk("skip_en_ignored", 32'(flash_req | ram_we), 32'd0);
    chk("skip_still_done", 32'(copy_done), 32'd1);

    // Directed data pattern, flash acks on the 3rd request cycle
    for (int i = 0; i < WORDS; i++) flash_mem[i] = 32'h1111_1111 * 32'(i + 1);
    flash_mem[WORDS] = word_sum();
    do_reset(1'b1);
    run_copy(3, 1, 1'b0, -1, 200);
    finish_check("pattern", 1'b1);

    // RAM backpressure: ready only on the 6th write cycle
    for (int i = 0; i < WORDS; i++) flash_mem[i] = $urandom();
    flash_mem[WORDS] = word_sum();
    do_reset(1'b1);
    run_copy(1, 6, 1'b0, -1, 300);
    finish_check("backpressure", 1'b1);

    // Flash never answers
    do_reset(1'b1);
    run_copy(0, 1, 1'b0, -1, 100);
    chk("to_end_reached", 32'(res_end), 32'd1);
    chk("to_rd_cycles", 32'(res_rd_cycles), 32'(TIMEOUT));
    chk("to_copy_err", 32'(copy_err), 32'd1);
    chk("to_copy_done", 32'(copy_done), 32'd0);
    chk("to_writes", 32'(res_writes), 32'd0);
    repeat (4) tick();
    chk("to_cpu_rst_b", 32'(cpu_rst_b), 32'd0);
    chk("to_err_sticky", 32'(copy_err), 32'd1);
    chk("to_quiet", 32'(flash_req | ram_we), 32'd0);

    // Reset while word 2 is being fetched, then a full rerun
    for (int i = 0; i < WORDS; i++) flash_mem[i] = $urandom();
    flash_mem[WORDS] = word_sum();
    do_reset(1'b1);
    run_copy(2, 2, 1'b0, 2, 200);
    chk("abort_at_word2", 32'(res_writes), 32'd2);
    rst_b = 1'b0;
    tick();
    chk_quiet("abort");
    do_reset(1'b1);
    run_copy(2, 2, 1'b0, -1, 200);
    finish_check("rerun", 1'b1);

`ifdef BOOT_COPY_CHKSUM_EN
    // Checksum trailer: matching and off-by-one
    for (int i = 0; i < WORDS; i++) flash_mem[i] = 32'(i + 1);
    flash_mem[WORDS] = 32'd10;
    do_reset(1'b1);
    run_copy(1, 1, 1'b0, -1, 200);
    finish_check("chk_good", 1'b1);
    flash_mem[WORDS] = 32'd11;
    do_reset(1'b1);
    run_copy(1, 1, 1'b0, -1, 200);
    finish_check("chk_bad", 1'b0);
`endif

    // Random data, random latencies, stray handshakes
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < WORDS; i++) flash_mem[i] = $urandom();
      flash_mem[WORDS] = word_sum() + 32'($urandom_range(0, 1));
      exp_ok = CHK_EN ? (flash_mem[WORDS] == word_sum()) : 1'b1;
      do_reset(1'b1);
      run_copy(0, 0, 1'b1, -1, 400);
      finish_check("random", exp_ok);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
